// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS datapath and its control unit:
// ALU operation codes, mux select encodings, opcodes and field helpers.
package mips_pkg;

   // Register file geometry
   localparam int NUM_REGS = 32;
   localparam int REG_AW   = 5;

   // ALU operations (3-bit alu_control); unlisted codes yield 0
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // ALU operand B selects
   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   // Next-PC selects (2'b11 aliases the ALU result)
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Opcodes understood by the control unit
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // Sign-extend a 16-bit immediate to a full word
   function automatic logic [31:0] sign_ext(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

   // Pseudo-direct jump target: top nibble of PC, 26-bit index, word aligned
   function automatic logic [31:0] jump_target(input logic [31:0] pc,
                                               input logic [25:0] index);
      return {pc[31:28], index, 2'b00};
   endfunction

endpackage

// File: rtl/multicycle_datapath_register_file.sv
// 32x32 register file: two combinational read ports, one write port
// committed on the clock edge, r0 hardwired to zero, async active-low clear.
module register_file
   import mips_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] i_ra1,
   input  logic [REG_AW-1:0] i_ra2,
   input  logic              i_we,
   input  logic [REG_AW-1:0] i_wa,
   input  logic [31:0]       i_wd,
   output logic [31:0]       o_rd1,
   output logic [31:0]       o_rd2
);

   logic [31:0] r_regs [NUM_REGS];

   // Clear everything on reset; otherwise commit one write per edge, never to r0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we && (i_wa != '0)) begin
         r_regs[i_wa] <= i_wd;
      end
   end

   // Reads see pre-edge contents, so a same-cycle write is not forwarded
   assign o_rd1 = (i_ra1 == '0) ? 32'h0 : r_regs[i_ra1];
   assign o_rd2 = (i_ra2 == '0) ? 32'h0 : r_regs[i_ra2];

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS datapath: holds PC, IR, MDR, A, B, ALUOut and the register
// file, and executes one control word from the control unit per clock.
module multicycle_datapath
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_to_reg,
   input  logic        reg_dest,
   input  logic        i_or_d,
   input  logic        alu_src_a,
   input  logic        ir_write,
   input  logic        mem_write,
   input  logic        pc_write,
   input  logic        branch,
   input  logic        reg_write,
   input  logic [1:0]  alu_src_b,
   input  logic [1:0]  pc_src,
   input  logic [2:0]  alu_control,
   output logic [5:0]  opcode,
   output logic [5:0]  funct,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic [31:0] mem_rdata
);

   // Architectural and inter-cycle state
   logic [31:0] r_pc;
   logic [31:0] r_ir;
   logic [31:0] r_mdr;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [31:0] r_alu_out;

   // Combinational datapath nets
   logic [31:0]       w_rd1;
   logic [31:0]       w_rd2;
   logic [31:0]       w_sign_imm;
   logic [31:0]       w_src_a;
   logic [31:0]       w_src_b;
   logic [31:0]       w_alu_result;
   logic              w_zero;
   logic [31:0]       w_pc_next;
   logic              w_pc_en;
   logic [REG_AW-1:0] w_wr_addr;
   logic [31:0]       w_wr_data;

   // Instruction fields fed back to the control unit
   assign opcode = r_ir[31:26];
   assign funct  = r_ir[5:0];

   // Unified memory port
   assign mem_addr  = i_or_d ? r_alu_out : r_pc;
   assign mem_wdata = r_b;
   assign mem_we    = mem_write;

   // Write-back destination and data use the IR as it stands before the edge
   assign w_wr_addr = reg_dest ? r_ir[15:11] : r_ir[20:16];
   assign w_wr_data = mem_to_reg ? r_mdr : r_alu_out;

   register_file u_register_file (
      .clk   (clk),
      .rst_n (reset),
      .i_ra1 (r_ir[25:21]),
      .i_ra2 (r_ir[20:16]),
      .i_we  (reg_write),
      .i_wa  (w_wr_addr),
      .i_wd  (w_wr_data),
      .o_rd1 (w_rd1),
      .o_rd2 (w_rd2)
   );

   assign w_sign_imm = sign_ext(r_ir[15:0]);
   assign w_src_a    = alu_src_a ? r_a : r_pc;

   // ALU operand B selection
   always_comb begin
      w_src_b = r_b;
      case (alu_src_b)
         SRCB_REG:     w_src_b = r_b;
         SRCB_FOUR:    w_src_b = 32'd4;
         SRCB_IMM:     w_src_b = w_sign_imm;
         SRCB_IMM_SH2: w_src_b = {w_sign_imm[29:0], 2'b00};
         default:      w_src_b = r_b;
      endcase
   end

   // ALU: wrap-around arithmetic, signed compare for slt, unused codes give 0
   always_comb begin
      w_alu_result = 32'h0;
      case (alu_control)
         ALU_ADD: w_alu_result = w_src_a + w_src_b;
         ALU_SUB: w_alu_result = w_src_a - w_src_b;
         ALU_AND: w_alu_result = w_src_a & w_src_b;
         ALU_OR:  w_alu_result = w_src_a | w_src_b;
         ALU_SLT: w_alu_result = ($signed(w_src_a) < $signed(w_src_b)) ? 32'd1 : 32'd0;
         default: w_alu_result = 32'h0;
      endcase
   end

   assign w_zero = (w_alu_result == 32'h0);

   // Next-PC selection; the spare encoding falls back to the ALU result
   always_comb begin
      w_pc_next = w_alu_result;
      case (pc_src)
         PCSRC_ALU:    w_pc_next = w_alu_result;
         PCSRC_ALUOUT: w_pc_next = r_alu_out;
         PCSRC_JUMP:   w_pc_next = jump_target(r_pc, r_ir[25:0]);
         default:      w_pc_next = w_alu_result;
      endcase
   end

   assign w_pc_en = pc_write | (branch & w_zero);

   // Program counter: unconditional write or taken branch
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc <= RESET_PC;
      end else if (w_pc_en) begin
         r_pc <= w_pc_next;
      end
   end

   // Instruction register: loads only during fetch
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ir <= 32'h0;
      end else if (ir_write) begin
         r_ir <= mem_rdata;
      end
   end

   // Inter-cycle holding registers reload unconditionally every cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mdr     <= 32'h0;
         r_a       <= 32'h0;
         r_b       <= 32'h0;
         r_alu_out <= 32'h0;
      end else begin
         r_mdr     <= mem_rdata;
         r_a       <= w_rd1;
         r_b       <= w_rd2;
         r_alu_out <= w_alu_result;
      end
   end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: the bench plays control unit and
// memory, and observes PC/ALUOut through mem_addr and B through mem_wdata.
module tb_multicycle_datapath;

   logic        clk;
   logic        reset;
   logic        mem_to_reg, reg_dest, i_or_d, alu_src_a, ir_write;
   logic        mem_write, pc_write, branch, reg_write;
   logic [1:0]  alu_src_b, pc_src;
   logic [2:0]  alu_control;
   logic [5:0]  opcode, funct;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we;

   int pass_cnt  = 0;
   int total_cnt = 0;

   multicycle_datapath #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .reset       (reset),
      .mem_to_reg  (mem_to_reg),
      .reg_dest    (reg_dest),
      .i_or_d      (i_or_d),
      .alu_src_a   (alu_src_a),
      .ir_write    (ir_write),
      .mem_write   (mem_write),
      .pc_write    (pc_write),
      .branch      (branch),
      .reg_write   (reg_write),
      .alu_src_b   (alu_src_b),
      .pc_src      (pc_src),
      .alu_control (alu_control),
      .opcode      (opcode),
      .funct       (funct),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_we      (mem_we),
      .mem_rdata   (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 time unit past it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Control word that changes no architectural state except the free-running registers
   task automatic set_idle();
      mem_to_reg = 0; reg_dest = 0; i_or_d = 0; alu_src_a = 0; ir_write = 0;
      mem_write = 0; pc_write = 0; branch = 0; reg_write = 0;
      alu_src_b = 2'b00; pc_src = 2'b00; alu_control = 3'b010;
   endtask

   // Load IR with a word without moving the PC
   task automatic load_ir(input logic [31:0] word);
      set_idle();
      mem_rdata = word;
      ir_write = 1;
      tick();
      set_idle();
   endtask

   // Execute an addi-style rt <= rs + imm over load/decode/execute/writeback
   task automatic run_addi(input logic [31:0] word);
      load_ir(word);
      tick();
      alu_src_a = 1; alu_src_b = 2'b10; tick();
      set_idle(); reg_write = 1; tick();
      set_idle();
   endtask

   task automatic test_reset();
      set_idle();
      mem_rdata = 32'h0;
      reset = 0;
      tick(); tick();
      total_cnt++; if (mem_addr !== 32'h0) $display("FAIL reset_pc: got %h expected %h", mem_addr, 32'h0); else pass_cnt++;
      total_cnt++; if (opcode !== 6'h0) $display("FAIL reset_opcode: got %h expected %h", opcode, 6'h0); else pass_cnt++;
      total_cnt++; if (funct !== 6'h0) $display("FAIL reset_funct: got %h expected %h", funct, 6'h0); else pass_cnt++;
      total_cnt++; if (mem_wdata !== 32'h0) $display("FAIL reset_wdata: got %h expected %h", mem_wdata, 32'h0); else pass_cnt++;
      total_cnt++; if (mem_we !== 1'b0) $display("FAIL reset_we: got %b expected %b", mem_we, 1'b0); else pass_cnt++;
      i_or_d = 1; #1;
      total_cnt++; if (mem_addr !== 32'h0) $display("FAIL reset_aluout: got %h expected %h", mem_addr, 32'h0); else pass_cnt++;
      mem_write = 1; #1;
      total_cnt++; if (mem_we !== 1'b1) $display("FAIL we_follows: got %b expected %b", mem_we, 1'b1); else pass_cnt++;
      set_idle(); #1;
      $display("reset: pc=%h opcode=%h funct=%h", mem_addr, opcode, funct);
   endtask

   task automatic test_fetch();
      mem_rdata = 32'h2008_0005;
      ir_write = 1; alu_src_b = 2'b01; pc_write = 1;
      reset = 1;
      tick();
      set_idle();
      total_cnt++; if (mem_addr !== 32'h4) $display("FAIL fetch_pc: got %h expected %h", mem_addr, 32'h4); else pass_cnt++;
      total_cnt++; if (opcode !== 6'h08) $display("FAIL fetch_opcode: got %h expected %h", opcode, 6'h08); else pass_cnt++;
      total_cnt++; if (funct !== 6'h05) $display("FAIL fetch_funct: got %h expected %h", funct, 6'h05); else pass_cnt++;
      $display("fetch: pc=%h opcode=%h", mem_addr, opcode);
   endtask

   task automatic test_addi();
      // IR already holds addi $8,$0,5: decode, execute, writeback
      tick();
      alu_src_a = 1; alu_src_b = 2'b10; tick();
      set_idle(); i_or_d = 1; #1;
      total_cnt++; if (mem_addr !== 32'h5) $display("FAIL addi_aluout: got %h expected %h", mem_addr, 32'h5); else pass_cnt++;
      set_idle(); reg_write = 1; tick();
      load_ir(32'h0108_0000);   // rs=rt=8
      tick();
      total_cnt++; if (mem_wdata !== 32'h5) $display("FAIL addi_r8: got %h expected %h", mem_wdata, 32'h5); else pass_cnt++;
      // 5 + sext(0xFFFA) = 0xFFFFFFFF aimed at rt=0
      load_ir(32'h0100_FFFA);
      tick();
      alu_src_a = 1; alu_src_b = 2'b10; tick();
      set_idle(); i_or_d = 1; #1;
      total_cnt++; if (mem_addr !== 32'hFFFF_FFFF) $display("FAIL r0_data: got %h expected %h", mem_addr, 32'hFFFF_FFFF); else pass_cnt++;
      set_idle(); reg_write = 1; tick();
      load_ir(32'h0000_0000);
      tick();
      total_cnt++; if (mem_wdata !== 32'h0) $display("FAIL r0_zero: got %h expected %h", mem_wdata, 32'h0); else pass_cnt++;
      $display("addi: r8=5 written, r0 reads %h", mem_wdata);
   endtask

   task automatic test_beq();
      run_addi(32'h2009_0007);   // $9 = 7
      run_addi(32'h200A_0008);   // $10 = 8
      for (int k = 0; k < 3; k++) begin
         alu_src_b = 2'b01; pc_write = 1; tick();
         set_idle();
      end
      total_cnt++; if (mem_addr !== 32'h10) $display("FAIL beq_start_pc: got %h expected %h", mem_addr, 32'h10); else pass_cnt++;
      // beq $9,$9,3 : taken
      mem_rdata = 32'h1129_0003; ir_write = 1; alu_src_b = 2'b01; pc_write = 1; tick();
      set_idle(); alu_src_b = 2'b11; tick();
      set_idle();
      total_cnt++; if (mem_wdata !== 32'h7) $display("FAIL beq_b: got %h expected %h", mem_wdata, 32'h7); else pass_cnt++;
      alu_src_a = 1; alu_control = 3'b110; branch = 1; pc_src = 2'b01; tick();
      set_idle();
      total_cnt++; if (mem_addr !== 32'h20) $display("FAIL beq_taken: got %h expected %h", mem_addr, 32'h20); else pass_cnt++;
      $display("beq taken: pc=%h", mem_addr);
      // beq $9,$10,3 : not taken
      mem_rdata = 32'h112A_0003; ir_write = 1; alu_src_b = 2'b01; pc_write = 1; tick();
      set_idle(); alu_src_b = 2'b11; tick();
      set_idle(); alu_src_a = 1; alu_control = 3'b110; branch = 1; pc_src = 2'b01; tick();
      set_idle();
      total_cnt++; if (mem_addr !== 32'h24) $display("FAIL beq_not_taken: got %h expected %h", mem_addr, 32'h24); else pass_cnt++;
      $display("beq not taken: pc=%h", mem_addr);
   endtask

   task automatic test_lw_sw();
      load_ir(32'h8C0B_0040);   // lw $11,0x40($0)
      tick();
      alu_src_a = 1; alu_src_b = 2'b10; tick();
      set_idle(); i_or_d = 1; mem_rdata = 32'hDEAD_BEEF; #1;
      total_cnt++; if (mem_addr !== 32'h40) $display("FAIL lw_addr: got %h expected %h", mem_addr, 32'h40); else pass_cnt++;
      tick();
      set_idle(); reg_write = 1; mem_to_reg = 1; mem_rdata = 32'h0; tick();
      load_ir(32'hAC0B_0040);
      tick();
      total_cnt++; if (mem_wdata !== 32'hDEAD_BEEF) $display("FAIL lw_r11: got %h expected %h", mem_wdata, 32'hDEAD_BEEF); else pass_cnt++;
      $display("lw: r11=%h", mem_wdata);
      run_addi(32'h200C_1234);   // $12 = 0x1234
      load_ir(32'hAC0C_0040);   // sw $12,0x40($0)
      tick();
      alu_src_a = 1; alu_src_b = 2'b10; tick();
      set_idle(); i_or_d = 1; mem_write = 1; #1;
      total_cnt++; if (mem_addr !== 32'h40) $display("FAIL sw_addr: got %h expected %h", mem_addr, 32'h40); else pass_cnt++;
      total_cnt++; if (mem_wdata !== 32'h1234) $display("FAIL sw_wdata: got %h expected %h", mem_wdata, 32'h1234); else pass_cnt++;
      total_cnt++; if (mem_we !== 1'b1) $display("FAIL sw_we: got %b expected %b", mem_we, 1'b1); else pass_cnt++;
      $display("sw: addr=%h wdata=%h we=%b", mem_addr, mem_wdata, mem_we);
      tick();
      set_idle();
   endtask

   task automatic test_jump();
      // Build 0x8000_0000 in $13 by doubling 0x4000 seventeen times
      run_addi(32'h200D_4000);
      load_ir(32'h01AD_6820);   // add $13,$13,$13
      for (int k = 0; k < 17; k++) begin
         tick();
         alu_src_a = 1; tick();
         set_idle(); reg_write = 1; reg_dest = 1; tick();
         set_idle();
      end
      tick();
      alu_src_a = 1; alu_src_b = 2'b01; pc_write = 1; tick();
      set_idle();
      total_cnt++; if (mem_addr !== 32'h8000_0004) $display("FAIL jump_start_pc: got %h expected %h", mem_addr, 32'h8000_0004); else pass_cnt++;
      load_ir(32'h0800_0100);   // j index 0x100
      pc_src = 2'b10; pc_write = 1; branch = 1; tick();
      set_idle();
      total_cnt++; if (mem_addr !== 32'h8000_0400) $display("FAIL jump_pc: got %h expected %h", mem_addr, 32'h8000_0400); else pass_cnt++;
      $display("jump: pc=%h", mem_addr);
   endtask

   task automatic test_slt_async_reset();
      run_addi(32'h200E_FFFF);   // $14 = -1
      run_addi(32'h200F_0001);   // $15 = 1
      load_ir(32'h01CF_002A);   // slt rs=14 rt=15
      tick();
      alu_src_a = 1; alu_control = 3'b111; tick();
      set_idle(); i_or_d = 1; #1;
      total_cnt++; if (mem_addr !== 32'h1) $display("FAIL slt_result: got %h expected %h", mem_addr, 32'h1); else pass_cnt++;
      set_idle(); alu_src_a = 1; alu_control = 3'b011; tick();
      set_idle(); i_or_d = 1; #1;
      total_cnt++; if (mem_addr !== 32'h0) $display("FAIL alu_011: got %h expected %h", mem_addr, 32'h0); else pass_cnt++;
      $display("slt: -1 < 1 gives 1, op 011 gives %h", mem_addr);
      set_idle();
      // Assert reset between edges and look before the next edge
      #2 reset = 0;
      #1;
      total_cnt++; if (mem_addr !== 32'h0) $display("FAIL async_pc: got %h expected %h", mem_addr, 32'h0); else pass_cnt++;
      total_cnt++; if (funct !== 6'h0) $display("FAIL async_funct: got %h expected %h", funct, 6'h0); else pass_cnt++;
      total_cnt++; if (mem_wdata !== 32'h0) $display("FAIL async_b: got %h expected %h", mem_wdata, 32'h0); else pass_cnt++;
      i_or_d = 1; #1;
      total_cnt++; if (mem_addr !== 32'h0) $display("FAIL async_aluout: got %h expected %h", mem_addr, 32'h0); else pass_cnt++;
      set_idle();
      tick();
      // Fetch right after release: register file must read back cleared
      mem_rdata = 32'h01CF_002A; ir_write = 1; alu_src_b = 2'b01; pc_write = 1;
      reset = 1;
      tick();
      set_idle();
      total_cnt++; if (mem_addr !== 32'h4) $display("FAIL post_reset_pc: got %h expected %h", mem_addr, 32'h4); else pass_cnt++;
      tick();
      total_cnt++; if (mem_wdata !== 32'h0) $display("FAIL post_reset_r15: got %h expected %h", mem_wdata, 32'h0); else pass_cnt++;
      $display("async reset: pc=%h r15=%h", mem_addr, mem_wdata);
   endtask

   initial begin
      reset = 0;
      mem_rdata = 32'h0;
      set_idle();
      test_reset();
      test_fetch();
      test_addi();
      test_beq();
      test_lw_sw();
      test_jump();
      test_slt_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/multicycle_datapath.md
# multicycle_datapath

Multicycle MIPS datapath, the consumer end of the control interface. It holds the architectural and inter-cycle state (PC, IR, MDR, A, B, ALUOut, 32x32 register file) and executes one control word per clock. It returns `opcode` and `funct` from the IR to the control unit and drives the unified instruction/data memory port.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1  the single clock; every register updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_to_reg`, `reg_dest`, `i_or_d`, `alu_src_a`, `ir_write`, `mem_write`, `pc_write`, `branch`, `reg_write`  in  1 each  control word bits from the control unit.
- `alu_src_b`, `pc_src`  in  2 each  mux selects.
- `alu_control`  in  3  ALU operation.
- `opcode`, `funct`  out  6 each  IR[31:26] and IR[5:0].
- `mem_addr`  out  32  byte address to memory.
- `mem_wdata`  out  32  store data; equals B.
- `mem_we`  out  1  equals `mem_write`.
- `mem_rdata`  in  32  combinational read data for `mem_addr`.

## Operation
- **Address mux:** `i_or_d` = 0 selects PC; 1 selects ALUOut.
- **IR:** loads `mem_rdata` when `ir_write` = 1, otherwise holds. MDR loads `mem_rdata` every cycle.
- **A and B:** load register file ports rs (IR[25:21]) and rt (IR[20:16]) every cycle.
- **ALU operand A:** `alu_src_a` = 0 selects PC; 1 selects A.
- **ALU operand B:** `alu_src_b` 00 selects B; 01 selects 32'd4; 10 selects SignImm (IR[15:0] sign-extended); 11 selects SignImm<<2.
- **`alu_control`:**
  - 010 add; 110 sub; 000 and; 001 or; 111 slt (signed, result 0 or 1).
  - 011, 100 and 101 produce result 0.
  - Overflow is ignored (mod 2^32).
- **`zero`:** 1 when the ALU result is 32'h0. It is internal.
- **ALUOut:** loads the ALU result every cycle.
- **PC next:** `pc_src` 00 selects the ALU result; 01 selects ALUOut; 10 selects the jump target {PC[31:28], IR[25:0], 2'b00}; 11 selects the ALU result.
- **PC load:** PC loads when `pc_en` = `pc_write` | (`branch` & `zero`).
- **Register write:**
  - Destination: `reg_dest` = 1 selects rd (IR[15:11]); 0 selects rt.
  - Data: `mem_to_reg` = 1 selects MDR; 0 selects ALUOut.
  - The write happens on the edge when `reg_write` = 1.
  - A write to r0 is discarded; r0 always reads 0.
- **Register reads:** combinational. A read of a register being written in the same cycle returns the old value. The new value is visible the cycle after the edge.

## Timing
- **Reset:** while `reset` = 0, independent of `clk`:
  - PC = `RESET_PC`.
  - IR, MDR, A, B, ALUOut and all 32 registers = 0.
- **Outputs during reset:**
  - `opcode` = `funct` = 0.
  - `mem_addr` = `RESET_PC` when `i_or_d` = 0.
  - `mem_wdata` = 0.
  - `mem_we` follows `mem_write` combinationally; the control unit holds it 0 during reset.
- **Reset mid-instruction:** all partial state is discarded. The first edge after deassertion behaves as a fetch from `RESET_PC` when the control word is a fetch.
- **Latency:**
  - A value loaded into IR, A, B, MDR or ALUOut at edge N is usable in cycle N+1.
  - `opcode` and `funct` change the cycle after `ir_write`.
- **Combinational paths:** `mem_addr`, `mem_we`, the ALU result and `zero` depend on current register state and control inputs in the same cycle; no added latency.
- **Simultaneous events:**
  - `pc_write` and `branch` both 1: the PC loads (OR).
  - `ir_write` and `reg_write` in the same cycle: the register write uses the old IR fields.

## Structure
- Package `mips_pkg` holds:
  - ALU op localparams: `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`, `ALU_SLT`.
  - `alu_src_b` encodings: `SRCB_REG`, `SRCB_FOUR`, `SRCB_IMM`, `SRCB_IMM_SH2`.
  - `pc_src` encodings: `PCSRC_ALU`, `PCSRC_ALUOUT`, `PCSRC_JUMP`.
  - The shared opcode constants.
- One sub-module, `register_file`: two combinational read ports, one synchronous write port, r0 hardwired, async active-low reset.
- The ALU and all muxes are inline.

## Test plan
- **Reset then fetch:** hold `reset` = 0, then release with `mem_rdata` = 32'h2008_0005 and the fetch word (`ir_write` = 1, `alu_src_b` = 01, `pc_write` = 1) → PC = 4, `opcode` = 6'h08 next cycle.
- **addi:** IR = 32'h2008_0005 (addi $t0, $0, 5), ALU add with `alu_src_a` = 1, `alu_src_b` = 10, then `reg_write` = 1, `reg_dest` = 0, `mem_to_reg` = 0 → $8 = 5; a write attempt to r0 with data 0xFFFF_FFFF leaves r0 reading 0.
- **beq taken and not taken:** PC = 0x10, offset 3, A = B = 7 with `branch` = 1, `pc_src` = 01 → PC = 0x20. With A = 7, B = 8 → PC unchanged.
- **lw/sw:** ALUOut = 0x40, `i_or_d` = 1, `mem_rdata` = 0xDEADBEEF → MDR written to rt correctly. `mem_write` = 1 with B = 0x1234 → `mem_addr` = 0x40, `mem_wdata` = 0x1234, `mem_we` = 1.
- **jump:** PC = 0x8000_0004, IR[25:0] = 0x000_0100, `pc_src` = 10, `pc_write` = 1 → PC = 0x8000_0400.
- **slt and async reset:** A = 32'hFFFF_FFFF, B = 1 → ALUOut = 1. Asserting `reset` mid-cycle immediately forces PC = `RESET_PC` and all registers to 0, without waiting for a clock edge.
